// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage: NOP encoding,
// fetch FSM states and the control-transfer opcodes.
package if_stage_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DISCARD = 2'd1,
    ST_HOLD    = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Flush beats stall; without a write an unstalled
// register just drops its valid bit.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic        write_i,
  input  logic [31:0] flush_pc_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      pc_q    <= flush_pc_i;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (!stall_i) begin
      if (write_i) begin
        pc_q    <= pc_i;
        instr_q <= instr_i;
        valid_q <= 1'b1;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: drives the instruction memory handshake, tracks
// the PC, absorbs stalls in a one-word buffer and applies redirects.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] instr_mem_address_o,
  output logic        instr_mem_req_o,
  input  logic        instr_mem_ack_i,
  input  logic [31:0] instr_mem_read_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jalr_taken_i,
  input  logic [31:0] jalr_target_i,
  output logic [31:0] pc_reg_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_instr_o,
  output logic        if_id_valid_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  buf_q, buf_d;
  logic         redirect;
  logic [31:0]  target;
  logic         ifid_write;
  logic [31:0]  ifid_instr;

  // JALR comes from an older instruction than a branch in ID, so it wins.
  assign redirect = jalr_taken_i | branch_taken_i;
  assign target   = jalr_taken_i ? jalr_target_i : branch_target_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      buf_q   <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_d      = buf_q;
    ifid_write = 1'b0;
    ifid_instr = instr_mem_read_i;
    addr_d     = (state_q == ST_FETCH) ? pc_q : addr_q;
    unique case (state_q)
      ST_FETCH: begin
        if (redirect) begin
          pc_d    = target;
          // With a response still outstanding, wait it out at the old address.
          state_d = instr_mem_ack_i ? ST_FETCH : ST_DISCARD;
        end else if (instr_mem_ack_i) begin
          if (stall_i) begin
            buf_d   = instr_mem_read_i;
            state_d = ST_HOLD;
          end else begin
            pc_d       = pc_q + 32'd4;
            ifid_write = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        ifid_instr = buf_q;
        if (redirect) begin
          pc_d    = target;
          state_d = ST_FETCH;
        end else if (!stall_i) begin
          pc_d       = pc_q + 32'd4;
          ifid_write = 1'b1;
          state_d    = ST_FETCH;
        end
      end
      ST_DISCARD: begin
        if (redirect) pc_d = target;
        if (instr_mem_ack_i) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  assign instr_mem_req_o     = (state_q != ST_HOLD);
  assign instr_mem_address_o = (state_q == ST_DISCARD) ? addr_q : pc_q;
  assign pc_reg_o            = pc_q;

  if_id_reg #(.RESET_PC(RESET_PC)) u_if_id_reg (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (redirect),
    .stall_i    (stall_i),
    .write_i    (ifid_write),
    .flush_pc_i (target),
    .pc_i       (pc_q),
    .instr_i    (ifid_instr),
    .pc_o       (if_id_pc_o),
    .instr_o    (if_id_instr_o),
    .valid_o    (if_id_valid_o)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: inputs change on the falling edge, outputs are
// checked on the following falling edge against hand-computed values.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic [31:0] instr_mem_address_o;
  logic        instr_mem_req_o;
  logic        instr_mem_ack_i;
  logic [31:0] instr_mem_read_i;
  logic        stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        jalr_taken_i;
  logic [31:0] jalr_target_i;
  logic [31:0] pc_reg_o;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_instr_o;
  logic        if_id_valid_o;

  int total = 0;
  int bad   = 0;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk                 (clk),
    .reset               (reset),
    .instr_mem_address_o (instr_mem_address_o),
    .instr_mem_req_o     (instr_mem_req_o),
    .instr_mem_ack_i     (instr_mem_ack_i),
    .instr_mem_read_i    (instr_mem_read_i),
    .stall_i             (stall_i),
    .branch_taken_i      (branch_taken_i),
    .branch_target_i     (branch_target_i),
    .jalr_taken_i        (jalr_taken_i),
    .jalr_target_i       (jalr_target_i),
    .pc_reg_o            (pc_reg_o),
    .if_id_pc_o          (if_id_pc_o),
    .if_id_instr_o       (if_id_instr_o),
    .if_id_valid_o       (if_id_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    instr_mem_ack_i  = 1'b0;
    instr_mem_read_i = 32'h0;
    stall_i          = 1'b0;
    branch_taken_i   = 1'b0;
    branch_target_i  = 32'h0;
    jalr_taken_i     = 1'b0;
    jalr_target_i    = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    total++; if (pc_reg_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_pc got %h want %h", pc_reg_o, 32'h0); end
    total++; if (if_id_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got %b want 0", if_id_valid_o); end
    total++; if (if_id_instr_o !== 32'h0000_0013) begin bad++; $display("[TB] FAIL reset_instr got %h want 00000013", if_id_instr_o); end
    total++; if (if_id_pc_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_ifid_pc got %h want 0", if_id_pc_o); end
    total++; if (instr_mem_req_o !== 1'b1 || instr_mem_address_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_req got %b/%h want 1/0", instr_mem_req_o, instr_mem_address_o); end
    reset = 1'b0;
  endtask

  // Ack every cycle: fetches 0,4,8,C; IF/ID trails the PC by one fetch.
  task automatic test_sequential();
    logic [31:0] exp_pc;
    logic [31:0] word;
    exp_pc = 32'h0;
    for (int i = 0; i < 4; i++) begin
      total++; if (instr_mem_address_o !== exp_pc || instr_mem_req_o !== 1'b1) begin bad++; $display("[TB] FAIL seq_addr[%0d] got %h/%b want %h/1", i, instr_mem_address_o, instr_mem_req_o, exp_pc); end
      word = 32'hA000_0000 | exp_pc;
      instr_mem_ack_i  = 1'b1;
      instr_mem_read_i = word;
      @(negedge clk);
      total++; if (pc_reg_o !== exp_pc + 32'd4) begin bad++; $display("[TB] FAIL seq_pc[%0d] got %h want %h", i, pc_reg_o, exp_pc + 32'd4); end
      total++; if (if_id_pc_o !== exp_pc || if_id_instr_o !== word || if_id_valid_o !== 1'b1) begin bad++; $display("[TB] FAIL seq_ifid[%0d] got %h/%h/%b want %h/%h/1", i, if_id_pc_o, if_id_instr_o, if_id_valid_o, exp_pc, word); end
      exp_pc = exp_pc + 32'd4;
    end
    idle_inputs();
  endtask

  // Word for 0x10 arrives under stall, sits in the buffer for 3 stalled cycles.
  task automatic test_stall_hold();
    instr_mem_ack_i  = 1'b1;
    instr_mem_read_i = 32'hDEAD_0010;
    stall_i          = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      instr_mem_ack_i  = 1'b0;
      instr_mem_read_i = 32'h0;
      total++; if (pc_reg_o !== 32'h10) begin bad++; $display("[TB] FAIL hold_pc[%0d] got %h want 00000010", i, pc_reg_o); end
      total++; if (if_id_pc_o !== 32'hC || if_id_instr_o !== 32'hA000_000C || if_id_valid_o !== 1'b1) begin bad++; $display("[TB] FAIL hold_ifid[%0d] got %h/%h/%b want c/a000000c/1", i, if_id_pc_o, if_id_instr_o, if_id_valid_o); end
      total++; if (instr_mem_req_o !== 1'b0) begin bad++; $display("[TB] FAIL hold_req[%0d] got %b want 0", i, instr_mem_req_o); end
    end
    stall_i = 1'b0;
    @(negedge clk);
    total++; if (if_id_pc_o !== 32'h10 || if_id_instr_o !== 32'hDEAD_0010 || if_id_valid_o !== 1'b1) begin bad++; $display("[TB] FAIL release_ifid got %h/%h/%b want 10/dead0010/1", if_id_pc_o, if_id_instr_o, if_id_valid_o); end
    total++; if (pc_reg_o !== 32'h14 || instr_mem_req_o !== 1'b1) begin bad++; $display("[TB] FAIL release_pc got %h/%b want 14/1", pc_reg_o, instr_mem_req_o); end
  endtask

  // Branch and JALR together, under stall: JALR target wins, flush beats stall.
  task automatic test_dual_redirect();
    instr_mem_ack_i  = 1'b1;
    instr_mem_read_i = 32'h5555_0014;
    stall_i          = 1'b1;
    branch_taken_i   = 1'b1;
    branch_target_i  = 32'h100;
    jalr_taken_i     = 1'b1;
    jalr_target_i    = 32'h200;
    @(negedge clk);
    idle_inputs();
    total++; if (pc_reg_o !== 32'h200) begin bad++; $display("[TB] FAIL dual_pc got %h want 00000200", pc_reg_o); end
    total++; if (if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h0000_0013 || if_id_pc_o !== 32'h200) begin bad++; $display("[TB] FAIL dual_ifid got %h/%h/%b want 200/00000013/0", if_id_pc_o, if_id_instr_o, if_id_valid_o); end
    total++; if (instr_mem_address_o !== 32'h200 || instr_mem_req_o !== 1'b1) begin bad++; $display("[TB] FAIL dual_addr got %h/%b want 200/1", instr_mem_address_o, instr_mem_req_o); end
  endtask

  // Redirect to 0x40 while the fetch of 0x8 is outstanding.
  task automatic test_redirect_pending();
    instr_mem_ack_i = 1'b1;
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h8;
    @(negedge clk);
    idle_inputs();
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h40;
    @(negedge clk);
    idle_inputs();
    total++; if (pc_reg_o !== 32'h40 || instr_mem_address_o !== 32'h8 || instr_mem_req_o !== 1'b1) begin bad++; $display("[TB] FAIL pend_redir got pc %h addr %h req %b want 40/8/1", pc_reg_o, instr_mem_address_o, instr_mem_req_o); end
    @(negedge clk);
    total++; if (instr_mem_address_o !== 32'h8) begin bad++; $display("[TB] FAIL pend_wait_addr got %h want 00000008", instr_mem_address_o); end
    instr_mem_ack_i  = 1'b1;
    instr_mem_read_i = 32'hBAD0_0008;
    @(negedge clk);
    total++; if (instr_mem_address_o !== 32'h40 || if_id_valid_o !== 1'b0 || pc_reg_o !== 32'h40) begin bad++; $display("[TB] FAIL pend_drop got addr %h valid %b pc %h want 40/0/40", instr_mem_address_o, if_id_valid_o, pc_reg_o); end
    instr_mem_read_i = 32'h1111_0040;
    @(negedge clk);
    idle_inputs();
    total++; if (if_id_pc_o !== 32'h40 || if_id_instr_o !== 32'h1111_0040 || if_id_valid_o !== 1'b1 || pc_reg_o !== 32'h44) begin bad++; $display("[TB] FAIL pend_next got %h/%h/%b pc %h want 40/11110040/1 pc 44", if_id_pc_o, if_id_instr_o, if_id_valid_o, pc_reg_o); end
  endtask

  task automatic test_wrap();
    instr_mem_ack_i = 1'b1;
    jalr_taken_i    = 1'b1;
    jalr_target_i   = 32'hFFFF_FFFC;
    @(negedge clk);
    idle_inputs();
    instr_mem_ack_i  = 1'b1;
    instr_mem_read_i = 32'h7777_FFFC;
    @(negedge clk);
    idle_inputs();
    total++; if (pc_reg_o !== 32'h0) begin bad++; $display("[TB] FAIL wrap_pc got %h want 00000000", pc_reg_o); end
    total++; if (if_id_pc_o !== 32'hFFFF_FFFC || if_id_instr_o !== 32'h7777_FFFC || if_id_valid_o !== 1'b1) begin bad++; $display("[TB] FAIL wrap_ifid got %h/%h/%b want fffffffc/7777fffc/1", if_id_pc_o, if_id_instr_o, if_id_valid_o); end
  endtask

  // One-cycle reset while in DISCARD must land in FETCH at RESET_PC.
  task automatic test_reset_in_discard();
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h80;
    @(negedge clk);
    idle_inputs();
    total++; if (pc_reg_o !== 32'h80 || instr_mem_address_o !== 32'h0) begin bad++; $display("[TB] FAIL disc_enter got pc %h addr %h want 80/0", pc_reg_o, instr_mem_address_o); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (pc_reg_o !== 32'h0 || instr_mem_address_o !== 32'h0 || instr_mem_req_o !== 1'b1 || if_id_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL disc_reset got pc %h addr %h req %b valid %b want 0/0/1/0", pc_reg_o, instr_mem_address_o, instr_mem_req_o, if_id_valid_o); end
    instr_mem_ack_i  = 1'b1;
    instr_mem_read_i = 32'h2222_0000;
    @(negedge clk);
    idle_inputs();
    total++; if (if_id_pc_o !== 32'h0 || if_id_instr_o !== 32'h2222_0000 || if_id_valid_o !== 1'b1 || pc_reg_o !== 32'h4) begin bad++; $display("[TB] FAIL disc_post got %h/%h/%b pc %h want 0/22220000/1 pc 4", if_id_pc_o, if_id_instr_o, if_id_valid_o, pc_reg_o); end
  endtask

  // No ack and no stall: IF/ID goes invalid, PC and address hold.
  task automatic test_no_ack();
    @(negedge clk);
    total++; if (if_id_valid_o !== 1'b0 || pc_reg_o !== 32'h4 || instr_mem_address_o !== 32'h4) begin bad++; $display("[TB] FAIL noack got valid %b pc %h addr %h want 0/4/4", if_id_valid_o, pc_reg_o, instr_mem_address_o); end
    total++; if (if_id_pc_o !== 32'h0) begin bad++; $display("[TB] FAIL noack_ifid_pc got %h want 0", if_id_pc_o); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_hold();
    test_dual_redirect();
    test_redirect_pending();
    test_wrap();
    test_reset_in_discard();
    test_no_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
